prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 141 ++++++++++++++
 tb/tb_prog_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: accepts a length-prefixed, checksummed word stream,
// writes the payload words into data memory starting at address 0, and
// releases the downstream core once the checksum has been verified.
module prog_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_run,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] len_reg, len_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             mem_we_reg, mem_we_next;
    logic [WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
    logic             in_ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             error_reg;
    logic             cpu_run_reg;

    logic             xfer;
    logic [WIDTH-1:0] csum_total;
    logic [WIDTH-1:0] count_inc;

    // in_ready_reg mirrors "state is LEN/DATA/CSUM", so this is the handshake.
    assign xfer       = in_valid & in_ready_reg;
    // Modulo-2^WIDTH arithmetic: carries out of the top bit are dropped.
    assign csum_total = sum_reg + in_data;
    assign count_inc  = count_reg + 1'b1;

    // Next-state, counter, checksum and write-port decode.
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        count_next     = count_reg;
        sum_next       = sum_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_LEN;
                    count_next = '0;
                    sum_next   = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    len_next   = in_data;
                    state_next = (in_data == '0) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = count_reg;
                    mem_wdata_next = in_data;
                    count_next     = count_inc;
                    sum_next       = csum_total;
                    // count never exceeds len-1 here, so count_inc cannot wrap.
                    if (count_inc == len_reg) begin
                        state_next = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_next = (csum_total == '0) ? S_DONE : S_ERR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and registered outputs; status flags decode the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            count_reg     <= '0;
            sum_reg       <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            cpu_run_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            count_reg     <= count_next;
            sum_reg       <= sum_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            in_ready_reg  <= (state_next == S_LEN) || (state_next == S_DATA) ||
                             (state_next == S_CSUM);
            busy_reg      <= (state_next == S_LEN) || (state_next == S_DATA) ||
                             (state_next == S_CSUM);
            done_reg      <= (state_next == S_DONE);
            error_reg     <= (state_next == S_ERR);
            cpu_run_reg   <= (state_next == S_DONE);
        end
    end

    assign in_ready  = in_ready_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;
    assign cpu_run   = cpu_run_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: each task drives one scenario and
// checks the registered outputs on the falling edge after each rising edge.
module tb_prog_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run;
    logic       busy;
    logic       done;
    logic       error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Write log: every memory write the DUT performs, in order.
    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];

    prog_loader #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory side: a write lands on the rising edge where mem_we is high.
    always @(posedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            $display("write addr=%02h data=%02h", mem_addr, mem_wdata);
        end
    end

    // Advance one full cycle, ending on a falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Present one word for exactly one cycle (stimulus only).
    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++; if (in_ready !== 1'b0)  $display("FAIL reset_in_ready got=%b exp=0", in_ready);   else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)      $display("FAIL reset_busy got=%b exp=0", busy);           else pass_cnt++;
        total_cnt++; if (done !== 1'b0)      $display("FAIL reset_done got=%b exp=0", done);           else pass_cnt++;
        total_cnt++; if (error !== 1'b0)     $display("FAIL reset_error got=%b exp=0", error);         else pass_cnt++;
        total_cnt++; if (cpu_run !== 1'b0)   $display("FAIL reset_cpu_run got=%b exp=0", cpu_run);     else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0)    $display("FAIL reset_mem_we got=%b exp=0", mem_we);       else pass_cnt++;
        total_cnt++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr got=%h exp=00", mem_addr);  else pass_cnt++;
        total_cnt++; if (mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata got=%h exp=00", mem_wdata); else pass_cnt++;
    endtask

    // Payload 0A,0B,0C sums to 0x21; its two's complement 0xDF closes the checksum.
    task automatic test_back_to_back();
        logic [7:0] s [5];
        s = '{8'h03, 8'h0A, 8'h0B, 8'h0C, 8'hDF};
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_len_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1)     $display("FAIL b2b_len_busy got=%b exp=1", busy);      else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = s[i];
            tick();
            if (i >= 1 && i <= 3) begin
                total_cnt++; if (mem_we !== 1'b1) $display("FAIL b2b_we%0d got=%b exp=1", i, mem_we); else pass_cnt++;
                total_cnt++; if (mem_addr !== 8'(i - 1)) $display("FAIL b2b_addr%0d got=%h exp=%h", i, mem_addr, 8'(i - 1)); else pass_cnt++;
                total_cnt++; if (mem_wdata !== s[i]) $display("FAIL b2b_wdata%0d got=%h exp=%h", i, mem_wdata, s[i]); else pass_cnt++;
            end else begin
                total_cnt++; if (mem_we !== 1'b0) $display("FAIL b2b_we%0d got=%b exp=0", i, mem_we); else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        total_cnt++; if (done !== 1'b1)     $display("FAIL b2b_done got=%b exp=1", done);       else pass_cnt++;
        total_cnt++; if (cpu_run !== 1'b1)  $display("FAIL b2b_cpu_run got=%b exp=1", cpu_run); else pass_cnt++;
        total_cnt++; if (error !== 1'b0)    $display("FAIL b2b_error got=%b exp=0", error);     else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_ready_done got=%b exp=0", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (wr_addr_q.size() !== 3) $display("FAIL b2b_write_count got=%0d exp=3", wr_addr_q.size()); else pass_cnt++;
    endtask

    task automatic test_bad_checksum();
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (cpu_run !== 1'b0) $display("FAIL bad_restart_cpu_run got=%b exp=0", cpu_run); else pass_cnt++;
        send(8'h03); send(8'h0A); send(8'h0B); send(8'h0C); send(8'hE8);
        total_cnt++; if (error !== 1'b1)   $display("FAIL bad_error got=%b exp=1", error);     else pass_cnt++;
        total_cnt++; if (done !== 1'b0)    $display("FAIL bad_done got=%b exp=0", done);       else pass_cnt++;
        total_cnt++; if (cpu_run !== 1'b0) $display("FAIL bad_cpu_run got=%b exp=0", cpu_run); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)    $display("FAIL bad_busy got=%b exp=0", busy);       else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (error !== 1'b0) $display("FAIL bad_retry_error got=%b exp=0", error); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1)  $display("FAIL bad_retry_busy got=%b exp=1", busy);   else pass_cnt++;
        send(8'h03); send(8'h0A); send(8'h0B); send(8'h0C); send(8'hDF);
        total_cnt++; if (done !== 1'b1)    $display("FAIL bad_retry_done got=%b exp=1", done);       else pass_cnt++;
        total_cnt++; if (cpu_run !== 1'b1) $display("FAIL bad_retry_cpu_run got=%b exp=1", cpu_run); else pass_cnt++;
        tick();
        total_cnt++; if (wr_addr_q.size() !== 6) $display("FAIL bad_write_count got=%0d exp=6", wr_addr_q.size()); else pass_cnt++;
    endtask

    task automatic test_zero_length();
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (cpu_run !== 1'b0)  $display("FAIL zero_cpu_run_drop got=%b exp=0", cpu_run); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL zero_ready got=%b exp=1", in_ready);       else pass_cnt++;
        send(8'h00); send(8'h00);
        total_cnt++; if (done !== 1'b1)    $display("FAIL zero_done got=%b exp=1", done);       else pass_cnt++;
        total_cnt++; if (cpu_run !== 1'b1) $display("FAIL zero_cpu_run got=%b exp=1", cpu_run); else pass_cnt++;
        tick();
        total_cnt++; if (wr_addr_q.size() !== 0) $display("FAIL zero_write_count got=%0d exp=0", wr_addr_q.size()); else pass_cnt++;
    endtask

    // 0x80 + 0x80 wraps to 0x00, so a 0x00 checksum passes.
    task automatic test_stall();
        logic [7:0] s [4];
        s = '{8'h02, 8'h80, 8'h80, 8'h00};
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            tick();
            if (i < 3) begin
                total_cnt++; if (busy !== 1'b1)   $display("FAIL stall_busy%0d got=%b exp=1", i, busy);     else pass_cnt++;
                total_cnt++; if (mem_we !== 1'b0) $display("FAIL stall_we%0d got=%b exp=0", i, mem_we);     else pass_cnt++;
            end
        end
        total_cnt++; if (done !== 1'b1)  $display("FAIL stall_done got=%b exp=1", done);   else pass_cnt++;
        total_cnt++; if (error !== 1'b0) $display("FAIL stall_error got=%b exp=0", error); else pass_cnt++;
        total_cnt++; if (wr_addr_q.size() !== 2) $display("FAIL stall_write_count got=%0d exp=2", wr_addr_q.size()); else pass_cnt++;
        if (wr_addr_q.size() == 2) begin
            total_cnt++; if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 8'h80) $display("FAIL stall_write0 got=(%h,%h) exp=(00,80)", wr_addr_q[0], wr_data_q[0]); else pass_cnt++;
            total_cnt++; if (wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 8'h80) $display("FAIL stall_write1 got=(%h,%h) exp=(01,80)", wr_addr_q[1], wr_data_q[1]); else pass_cnt++;
        end
    endtask

    // Reset lands while word 2 of 4 is still pending on the write port and word 3 is offered.
    task automatic test_reset_mid();
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'h04); send(8'h01); send(8'h02);
        total_cnt++; if (mem_we !== 1'b1) $display("FAIL rmid_pending_we got=%b exp=1", mem_we); else pass_cnt++;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h03;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        total_cnt++; if (mem_we !== 1'b0)   $display("FAIL rmid_we got=%b exp=0", mem_we);         else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)     $display("FAIL rmid_busy got=%b exp=0", busy);         else pass_cnt++;
        total_cnt++; if (cpu_run !== 1'b0)  $display("FAIL rmid_cpu_run got=%b exp=0", cpu_run);   else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rmid_ready got=%b exp=0", in_ready);    else pass_cnt++;
        tick();
        total_cnt++; if (wr_addr_q.size() !== 2) $display("FAIL rmid_write_count got=%0d exp=2", wr_addr_q.size()); else pass_cnt++;
        if (wr_addr_q.size() == 2) begin
            total_cnt++; if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 8'h01) $display("FAIL rmid_write0 got=(%h,%h) exp=(00,01)", wr_addr_q[0], wr_data_q[0]); else pass_cnt++;
            total_cnt++; if (wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 8'h02) $display("FAIL rmid_write1 got=(%h,%h) exp=(01,02)", wr_addr_q[1], wr_data_q[1]); else pass_cnt++;
        end
    endtask

    // Payload 11,22 sums to 0x33; checksum 0xCD. Starts from IDLE.
    task automatic test_ignored_inputs();
        clear_log();
        in_valid = 1'b1;
        in_data  = 8'h05;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL ign_idle_ready%0d got=%b exp=0", i, in_ready); else pass_cnt++;
            total_cnt++; if (busy !== 1'b0)     $display("FAIL ign_idle_busy%0d got=%b exp=0", i, busy);     else pass_cnt++;
        end
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'h02); send(8'h11);
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1)     $display("FAIL ign_data_busy got=%b exp=1", busy);      else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL ign_data_ready got=%b exp=1", in_ready); else pass_cnt++;
        send(8'h22); send(8'hCD);
        total_cnt++; if (done !== 1'b1)    $display("FAIL ign_done got=%b exp=1", done);       else pass_cnt++;
        total_cnt++; if (cpu_run !== 1'b1) $display("FAIL ign_cpu_run got=%b exp=1", cpu_run); else pass_cnt++;
        tick();
        total_cnt++; if (wr_addr_q.size() !== 2) $display("FAIL ign_write_count got=%0d exp=2", wr_addr_q.size()); else pass_cnt++;
        if (wr_addr_q.size() == 2) begin
            total_cnt++; if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 8'h11) $display("FAIL ign_write0 got=(%h,%h) exp=(00,11)", wr_addr_q[0], wr_data_q[0]); else pass_cnt++;
            total_cnt++; if (wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 8'h22) $display("FAIL ign_write1 got=(%h,%h) exp=(01,22)", wr_addr_q[1], wr_data_q[1]); else pass_cnt++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        test_reset();
        test_back_to_back();
        test_bad_checksum();
        test_zero_length();
        test_stall();
        test_reset_mid();
        test_ignored_inputs();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
